// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared IF->ID bus constants for the instruction queue.
// An entry is {inst[31:0], pc[31:0]}. When the CPU-wide header defines
// FS_TO_DS_BUS_WD, that value is used; otherwise the 64-bit default applies.
// Only constants live here; the queue introduces no new types.
`ifndef FS_TO_DS_BUS_WD
`define FS_TO_DS_BUS_WD 64
`endif

package inst_queue_pkg;

  localparam int FS_TO_DS_BUS_WD = `FS_TO_DS_BUS_WD;

  // Field offsets within one entry.
  localparam int PC_LSB   = 0;
  localparam int PC_MSB   = 31;
  localparam int INST_LSB = 32;
  localparam int INST_MSB = 63;

endpackage

// File: rtl/inst_queue.sv
// inst_queue: small in-order instruction FIFO that sits between IF and ID.
//
// Ports
//   clk             single clock, all state on posedge
//   resetn          asynchronous active-low reset
//   fs_to_iq_valid  IF presents an entry
//   fs_to_iq_bus    entry from IF, {inst, pc}
//   iq_allowin      queue takes an entry this cycle (drives IF's ds_allowin)
//   iq_to_ds_valid  head entry valid toward ID
//   iq_to_ds_bus    head entry toward ID
//   ds_allowin      ID takes the head entry this cycle
//   flush           drop all contents (redirect / exception)
//   iq_count        number of stored entries
//
// Build option
//   INST_QUEUE_BYPASS_EN  when defined, an entry arriving at an empty queue is
//                         shown to ID in the same cycle; if ID takes it, it is
//                         never written into storage.
//
// iq_allowin depends only on the registered count, so there is no
// combinational path from ds_allowin back to IF.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BUS_WD = FS_TO_DS_BUS_WD
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       fs_to_iq_valid,
  input  logic [BUS_WD-1:0]          fs_to_iq_bus,
  output logic                       iq_allowin,
  output logic                       iq_to_ds_valid,
  output logic [BUS_WD-1:0]          iq_to_ds_bus,
  input  logic                       ds_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [BUS_WD-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic              push, pop;

  assign empty      = (count == '0);
  assign iq_allowin = (count < CW'(DEPTH));
  assign iq_count   = count;

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  // Empty queue: the arriving entry is the head this cycle.
  assign bypass         = empty && fs_to_iq_valid && !flush;
  assign iq_to_ds_valid = (!empty || fs_to_iq_valid) && !flush;
  assign iq_to_ds_bus   = empty ? fs_to_iq_bus : mem[rd_ptr];
  // A bypassed entry that ID consumes is not stored.
  assign push = fs_to_iq_valid && iq_allowin && !flush && !(bypass && ds_allowin);
  // Only a stored head advances the read pointer.
  assign pop  = iq_to_ds_valid && ds_allowin && !empty;
`else
  assign iq_to_ds_valid = !empty && !flush;
  assign iq_to_ds_bus   = mem[rd_ptr];
  assign push = fs_to_iq_valid && iq_allowin && !flush;
  assign pop  = iq_to_ds_valid && ds_allowin;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fs_to_iq_bus;
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed bench with a scoreboard for inst_queue (DEPTH=4).
// Accepted pushes enqueue the expected entry; every handshake at the output
// dequeues and compares. Builds with or without INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  localparam int DEPTH  = 4;
  localparam int BUS_WD = 64;
`ifdef INST_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              fs_to_iq_valid;
  logic [BUS_WD-1:0] fs_to_iq_bus;
  logic              iq_allowin;
  logic              iq_to_ds_valid;
  logic [BUS_WD-1:0] iq_to_ds_bus;
  logic              ds_allowin;
  logic              flush;
  logic [2:0]        iq_count;

  inst_queue #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fs_to_iq_valid (fs_to_iq_valid),
    .fs_to_iq_bus   (fs_to_iq_bus),
    .iq_allowin     (iq_allowin),
    .iq_to_ds_valid (iq_to_ds_valid),
    .iq_to_ds_bus   (iq_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .flush          (flush),
    .iq_count       (iq_count)
  );

  always #5 clk = ~clk;

  logic [BUS_WD-1:0] sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  bit acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_WD-1:0] ent(input logic [31:0] pc);
    return {~pc ^ 32'h1357_9bdf, pc};
  endfunction

  // One clock: sample at negedge, then move to 1 time unit after posedge.
  task automatic step();
    logic [BUS_WD-1:0] e;
    @(negedge clk);
    if (fs_to_iq_valid && iq_allowin && !flush) begin
      sb.push_back(fs_to_iq_bus);
      acc = 1'b1;
    end
    if (iq_to_ds_valid && ds_allowin) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'(iq_to_ds_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("order", iq_to_ds_bus, e);
      end
    end
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    fs_to_iq_valid = 1'b0;
    ds_allowin     = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    ds_allowin = 1'b0;
    for (int i = 0; i < n; i++) begin
      fs_to_iq_valid = 1'b1;
      fs_to_iq_bus   = ent(base + 32'(4 * i));
      step();
    end
    fs_to_iq_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; fs_to_iq_valid = 1'b0; fs_to_iq_bus = '0;
    ds_allowin = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(iq_to_ds_valid), 64'd0);
    chk("rst_allowin", 64'(iq_allowin), 64'd1);
    chk("rst_count", 64'(iq_count), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back pushes with ID always ready.
    ds_allowin = 1'b1;
    fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0000);
    if (BYP == 0) chk("t1_no_passthru", 64'(iq_to_ds_valid), 64'd0);
    step();
    chk("t1_count_a", 64'(iq_count), 64'(1 - BYP));
    fs_to_iq_bus = ent(32'hbfc0_0004);
    step();
    chk("t1_count_b", 64'(iq_count), 64'(1 - BYP));
    drain("t1_drained");
    chk("t1_count_end", 64'(iq_count), 64'd0);

    // Fill to full with ID stalled; fifth entry must wait.
    fill(4, 32'hbfc0_0100);
    chk("t2_allowin_full", 64'(iq_allowin), 64'd0);
    chk("t2_count_full", 64'(iq_count), 64'd4);
    fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0110);
    acc = 1'b0;
    step();
    chk("t2_fifth_held", 64'(acc), 64'd0);
    chk("t2_count_held", 64'(iq_count), 64'd4);
    ds_allowin = 1'b1;
    for (int k = 0; k < 10 && !acc; k++) step();
    chk("t2_fifth_taken", 64'(acc), 64'd1);
    drain("t2_drained");

    // Flush a full queue while IF presents another entry.
    fill(4, 32'hbfc0_0200);
    flush = 1'b1; fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0210);
    #1;
    chk("t3_valid_in_flush", 64'(iq_to_ds_valid), 64'd0);
    step();
    flush = 1'b0; fs_to_iq_valid = 1'b0; ds_allowin = 1'b1;
    #1;
    chk("t3_count", 64'(iq_count), 64'd0);
    chk("t3_allowin", 64'(iq_allowin), 64'd1);
    chk("t3_valid", 64'(iq_to_ds_valid), 64'd0);
    // Push right after flush is accepted and returned.
    fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0220);
    acc = 1'b0;
    step();
    chk("t3_push_after", 64'(acc), 64'd1);
    drain("t3_drained");

    // Steady state at count 2 with push+pop every cycle; pointers wrap twice.
    fill(2, 32'hbfc0_0300);
    ds_allowin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0400 + 32'(4 * i));
      step();
      chk("t4_count", 64'(iq_count), 64'd2);
    end
    drain("t4_drained");

    // Asynchronous reset mid-stream.
    fill(3, 32'hbfc0_0500);
    chk("t5_count_pre", 64'(iq_count), 64'd3);
    resetn = 1'b0;
    #1;
    chk("t5_count", 64'(iq_count), 64'd0);
    chk("t5_valid", 64'(iq_to_ds_valid), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    ds_allowin = 1'b1;
    fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0600);
    #1;
    if (BYP == 0) chk("t5_latency", 64'(iq_to_ds_valid), 64'd0);
    step();
    drain("t5_drained");

`ifdef INST_QUEUE_BYPASS_EN
    // Same-cycle bypass at an empty queue.
    ds_allowin = 1'b1;
    fs_to_iq_valid = 1'b1; fs_to_iq_bus = ent(32'hbfc0_0010);
    #1;
    chk("t6_byp_valid", 64'(iq_to_ds_valid), 64'd1);
    chk("t6_byp_pc", 64'(iq_to_ds_bus[31:0]), 64'h0000_0000_bfc0_0010);
    step();
    fs_to_iq_valid = 1'b0;
    #1;
    chk("t6_count", 64'(iq_count), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of buffered entries; power of two, 2..16.
REQ-002 SHALL have parameter: BUS_WD, `FS_TO_DS_BUS_WD (64), entry width = {inst[31:0], pc[31:0]}.
REQ-003 SHALL have port: clk  in  1  single clock; all state on posedge.
REQ-004 SHALL have port: resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: fs_to_iq_valid  in  1  IF stage presents an entry.
REQ-006 SHALL have port: fs_to_iq_bus  in  BUS_WD  entry from IF.
REQ-007 SHALL have port: iq_allowin  out  1  queue accepts an entry this cycle; drives IF's ds_allowin.
REQ-008 SHALL have port: iq_to_ds_valid  out  1  head entry valid toward ID.
REQ-009 SHALL have port: iq_to_ds_bus  out  BUS_WD  head entry toward ID.
REQ-010 SHALL have port: ds_allowin  in  1  ID accepts an entry this cycle.
REQ-011 SHALL have port: flush  in  1  discard all contents (branch redirect or exception).
REQ-012 SHALL have port: iq_count  out  $clog2(DEPTH)+1  number of stored entries.

Function
REQ-013 SHALL define push = fs_to_iq_valid && iq_allowin && !flush, and pop = iq_to_ds_valid && ds_allowin.
REQ-014 SHALL drive iq_allowin = (iq_count < DEPTH); no same-cycle pass-through when full, so there is no combinational path from ds_allowin to iq_allowin.
REQ-015 SHALL drive iq_to_ds_valid = (iq_count != 0) && !flush, with iq_to_ds_bus = storage[rd_ptr].
REQ-016 SHALL write on push to storage[wr_ptr], increment wr_ptr modulo DEPTH, and make the entry visible at the output the next cycle (1-cycle latency).
REQ-017 SHALL increment rd_ptr modulo DEPTH on pop.
REQ-018 SHALL update count: push&&!pop +1; pop&&!push -1; both or neither unchanged.
REQ-019 SHALL preserve order: entries leave strictly in arrival order; no drop or duplicate except on flush.
REQ-020 SHALL clear, on flush, rd_ptr, wr_ptr and count to 0 at the next edge, discard any entry presented in the flush cycle, and perform no pop in that cycle.
REQ-021 SHALL allow push in the cycle after flush.
REQ-022 SHALL hold storage contents when neither push nor pop occurs; storage needs no reset.
REQ-023 SHALL make pointer wrap invisible: DEPTH consecutive push/pop pairs return the same sequence.

Reset
REQ-024 SHALL, while resetn=0, asynchronously force rd_ptr=0, wr_ptr=0 and count=0, hence iq_to_ds_valid=0, iq_allowin=1 and iq_count=0.
REQ-025 SHALL discard all contents on reset mid-operation; first valid output comes at least 1 cycle after the first push following deassertion.

Configuration
REQ-026 SHALL use the macro INST_QUEUE_BYPASS_EN.
REQ-027 SHALL, with INST_QUEUE_BYPASS_EN defined and when count==0 && fs_to_iq_valid && !flush, drive iq_to_ds_valid=1 and iq_to_ds_bus=fs_to_iq_bus in the same cycle; if ds_allowin=1 the entry is consumed and not stored (count stays 0), otherwise it is stored normally.
REQ-028 SHALL, without INST_QUEUE_BYPASS_EN, have a minimum latency of 1 cycle in all cases, as in REQ-016.

Structure
REQ-029 SHALL take BUS_WD and entry field offsets (pc [31:0], inst [63:32]) from the shared mycpu.h header constants; no new package types.
REQ-030 SHALL be a single module with no sub-module; storage is a reg array indexed by the pointers.

Verification
REQ-031 SHALL cover: reset, then push pc 0xbfc00000, 0xbfc00004 with ds_allowin=1 -> outputs in order, 1 cycle after each push; iq_count peaks at 1.
REQ-032 SHALL cover: ds_allowin=0, push 5 entries -> iq_allowin=0 after 4th; iq_count=4; 5th held by IF; then release -> 5 entries drain in order.
REQ-033 SHALL cover: full queue, flush=1 with fs_to_iq_valid=1 -> iq_to_ds_valid=0 that cycle; next cycle iq_count=0, iq_allowin=1, flushed entry absent.
REQ-034 SHALL cover: count=2, simultaneous push and pop for 8 cycles -> iq_count stays 2; pointers wrap twice; order preserved.
REQ-035 SHALL cover: resetn pulsed low mid-stream with count=3 -> immediately iq_count=0, iq_to_ds_valid=0.
REQ-036 SHALL cover: with INST_QUEUE_BYPASS_EN, empty queue, push pc 0xbfc00010 with ds_allowin=1 -> iq_to_ds_bus pc=0xbfc00010 the same cycle; iq_count remains 0.
